send_matrix_c: RTL and testbench
================================

// Module: send_matrix_c
// PURPOSE
//  Write-back stage downstream of the matrix-receive/compute path: drains result tiles Matrix_C_out
//  (4 tiles x 8x8 x 32b) to memory over an AXI4 write channel (AW/W/B). Tiles are placed row-major
//  in the full m x n C matrix per Matrix_type. One 8-beat INCR burst per tile row, 32 bursts per run.
// PARAMETERS
//  ADDR_W    32  AXI address width
//  BASE_ADDR 0   byte address of C[0][0]
//  TILE      8   tile edge (rows/cols); fixed 8, listed for package consistency
// PORTS
//  clk          in   1   clock; single clock domain
//  rst          in   1   asynchronous, active-high reset
//  writestart   in   1   start pulse; ignored unless IDLE
//  Matrix_type  in   2   0:m8n32 1:m16n16 2:m32n8, 3 treated as 0; sampled at writestart
//  Matrix_C_out in   32  [0:3][0:7][0:7] result tiles; held stable while busy=1
//  busy         out  1   high from cycle after accepted writestart until writedone
//  writedone    out  1   one-cycle completion pulse
//  write_err    out  1   sticky error flag (SEND_C_RESP_CHECK_EN only, else tied 0)
//  axi_awaddr/awlen/awsize/awburst/awvalid  out  ADDR_W/8/3/2/1 ; axi_awready in 1
//  axi_wdata/wstrb/wlast/wvalid  out  32/4/1/1 ; axi_wready in 1
//  axi_bresp in 2 ; axi_bvalid in 1 ; axi_bready out 1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; reset mid-burst abandons transfer, no writedone.
//  Constants: awlen=7, awsize=3'b010, awburst=2'b01, wstrb=4'hF whenever awvalid/wvalid high.
//  FSM IDLE->ADDR->DATA->RESP->(ADDR|DONE)->IDLE, one outstanding burst, W only after AW accepted.
//   IDLE: writestart -> latch type, tile=0,row=0, busy=1, ADDR.
//   ADDR: awvalid=1, awaddr stable until awvalid&&awready; then DATA, beat=0.
//   DATA: wvalid=1, wdata=Matrix_C_out[tile][row][beat]; advance on wvalid&&wready;
//         wlast=1 iff beat==7; accepted last beat -> RESP. wdata/wlast stable while stalled.
//   RESP: bready=1; on bvalid: if tile==3&&row==7 -> DONE else row++ (row 7 -> row 0, tile++), ADDR.
//   DONE: writedone=1 one cycle, busy=0, -> IDLE. Back-to-back writestart allowed next cycle.
//  Addressing: max_col=4/2/1 by type, n_dim=32/16/8; rb=tile/max_col, cb=tile%max_col;
//   awaddr = BASE_ADDR + (((rb*8+row)*n_dim + cb*8) << 2), computed in 16b, zero-extended, mod 2^ADDR_W.
//  Latency (zero-wait slave): 1 AW + 8 W + 1 B cycles per burst; writedone 321 cycles after start.
// CONFIGURATION
//  SEND_C_RESP_CHECK_EN defined: bresp!=2'b00 on bvalid sets write_err, skips remaining bursts,
//   goes to DONE (writedone still pulses); write_err clears on next accepted writestart.
//  Undefined: bresp ignored, write_err tied 0, all 32 bursts always issued.
// STRUCTURE
//  matrix_pkg: matrix_type_t enum, TILE_DIM=8, N_TILE=4, functions max_col(type), n_dim(type),
//   AXI constants (BURST_INCR, SIZE_4B, RESP_OKAY) shared with the receive block.
//  Sub-module c_tile_addr_gen: registered awaddr from {type,tile,row}, updated on burst advance.
// TESTING
//  1 type=0, C[t][r][c]={t,r,c} bytes, zero-wait slave -> 32 bursts; awaddr t0r0=0x000, t1r0=0x020,
//    t0r1=0x080, t3r7=0x3E0; each burst 8 beats wlast on 8th; writedone at cycle 321.
//  2 type=1 -> t2r0 awaddr=0x200, t3r7=0x3E0, t1r0=0x020; data order matches tile/row/beat.
//  3 type=2 -> t1r0=0x100, t3r7=0x3E0; every awaddr multiple of 0x20.
//  4 awready delayed 3 cycles, wready random 50% -> awaddr/wdata stable while stalled, 256 beats total,
//    no duplicates/losses; writestart pulsed mid-run ignored.
//  5 rst asserted in DATA beat 4 -> all outputs 0 immediately, no writedone; new writestart restarts t0r0.
//  6 SEND_C_RESP_CHECK_EN, bresp=2'b10 on burst 5 -> write_err=1, writedone, no 6th AW;
//    without macro same stimulus -> 32 bursts, write_err=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and AXI constants for the matrix receive/compute/send blocks.
// Tile placement helpers map a matrix shape to its tile-column count and row pitch.
package matrix_pkg;

    localparam int TILE_DIM = 8;
    localparam int N_TILE   = 4;

    typedef enum logic [1:0] {
        M8N32  = 2'd0,
        M16N16 = 2'd1,
        M32N8  = 2'd2,
        M_RSVD = 2'd3
    } matrix_type_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DONE
    } wr_state_t;

    localparam logic [7:0] BURST_LEN  = 8'd7;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Tiles per row of C; the reserved encoding behaves like m8n32.
    function automatic logic [2:0] max_col(matrix_type_t t);
        case (t)
            M16N16:  return 3'd2;
            M32N8:   return 3'd1;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [5:0] n_dim(matrix_type_t t);
        case (t)
            M16N16:  return 6'd16;
            M32N8:   return 6'd8;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/send_matrix_c_if.sv
// AXI4 write-channel bundle (AW/W/B) between the C write-back stage and memory.
interface send_matrix_c_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] axi_awaddr;
    logic [7:0]        axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [31:0]       axi_wdata;
    logic [3:0]        axi_wstrb;
    logic              axi_wlast;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;

    modport master (
        output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_bready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_bready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/send_matrix_c_tile_addr_gen.sv
// Registered burst start address for tile row {type, tile, row} inside the full C matrix.
// Loaded whenever the write FSM moves on to a new burst, so awaddr is a flop output.
module c_tile_addr_gen
    import matrix_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update_i,
    input  matrix_type_t      type_i,
    input  logic [1:0]        tile_i,
    input  logic [2:0]        row_i,
    output logic [ADDR_W-1:0] awaddr_o
);

    logic [2:0]        mc;
    logic [1:0]        rb;
    logic [1:0]        cb;
    logic [15:0]       elem_idx;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;

    // Element offset is kept to 16 bits, then zero-extended onto the base address.
    always_comb begin
        mc       = max_col(type_i);
        rb       = 2'(3'(tile_i) / mc);
        cb       = 2'(3'(tile_i) % mc);
        elem_idx = (16'(rb) * 16'(TILE_DIM) + 16'(row_i)) * 16'(n_dim(type_i))
                 + 16'(cb) * 16'(TILE_DIM);
        addr_d   = BASE_ADDR + ADDR_W'(elem_idx << 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
        end else if (update_i) begin
            addr_q <= addr_d;
        end
    end

    assign awaddr_o = addr_q;

endmodule

// File: rtl/send_matrix_c.sv
// Drains four 8x8 result tiles of C to memory: one 8-beat INCR burst per tile row.
// Optional SEND_C_RESP_CHECK_EN: a non-OKAY write response aborts the run and sets write_err.
module send_matrix_c
    import matrix_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TILE      = TILE_DIM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writestart,
    input  logic [1:0]  Matrix_type,
    input  logic [31:0] Matrix_C_out [0:N_TILE-1][0:TILE_DIM-1][0:TILE_DIM-1],
    output logic        busy,
    output logic        writedone,
    output logic        write_err,
    send_matrix_c_if.master axi
);

    wr_state_t         state_q, state_d;
    matrix_type_t      type_q, type_d;
    logic [1:0]        tile_q, tile_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        beat_q, beat_d;
    logic              busy_q, busy_d;
    logic              addr_upd;
    logic [ADDR_W-1:0] addr_q;
    logic              resp_err;
    logic              last_beat, last_row, last_tile;
    logic              aw_valid, w_valid;

    assign last_beat = (beat_q == 3'(TILE - 1));
    assign last_row  = (row_q == 3'(TILE - 1));
    assign last_tile = (tile_q == 2'(N_TILE - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        type_d   = type_q;
        tile_d   = tile_q;
        row_d    = row_q;
        beat_d   = beat_q;
        busy_d   = busy_q;
        addr_upd = 1'b0;
        case (state_q)
            S_IDLE: if (writestart) begin
                type_d   = matrix_type_t'(Matrix_type);
                tile_d   = '0;
                row_d    = '0;
                busy_d   = 1'b1;
                addr_upd = 1'b1;
                state_d  = S_ADDR;
            end
            S_ADDR: if (axi.axi_awready) begin
                beat_d  = '0;
                state_d = S_DATA;
            end
            S_DATA: if (axi.axi_wready) begin
                beat_d = beat_q + 3'd1;
                if (last_beat) state_d = S_RESP;
            end
            S_RESP: if (axi.axi_bvalid) begin
                if (resp_err || (last_tile && last_row)) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    row_d    = row_q + 3'd1;
                    tile_d   = last_row ? tile_q + 2'd1 : tile_q;
                    addr_upd = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            type_q  <= M8N32;
            tile_q  <= '0;
            row_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            type_q  <= type_d;
            tile_q  <= tile_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
        end
    end

    c_tile_addr_gen #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .update_i(addr_upd),
        .type_i  (type_d),
        .tile_i  (tile_d),
        .row_i   (row_d),
        .awaddr_o(addr_q)
    );

`ifdef SEND_C_RESP_CHECK_EN
    logic err_q, err_d;

    assign resp_err = (axi.axi_bresp != RESP_OKAY);

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && writestart) begin
            err_d = 1'b0;
        end else if (state_q == S_RESP && axi.axi_bvalid && resp_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign write_err = err_q;
`else
    logic unused_bresp;

    assign resp_err     = 1'b0;
    assign unused_bresp = ^axi.axi_bresp;
    assign write_err    = 1'b0;
`endif

    // Bus fields are forced to zero whenever their valid is low, so reset leaves all outputs at 0.
    assign aw_valid           = (state_q == S_ADDR);
    assign w_valid            = (state_q == S_DATA);
    assign axi.axi_awvalid    = aw_valid;
    assign axi.axi_awaddr     = aw_valid ? addr_q : '0;
    assign axi.axi_awlen      = aw_valid ? BURST_LEN : '0;
    assign axi.axi_awsize     = aw_valid ? SIZE_4B : '0;
    assign axi.axi_awburst    = aw_valid ? BURST_INCR : '0;
    assign axi.axi_wvalid     = w_valid;
    assign axi.axi_wdata      = w_valid ? Matrix_C_out[tile_q][row_q][beat_q] : '0;
    assign axi.axi_wstrb      = w_valid ? 4'hF : '0;
    assign axi.axi_wlast      = w_valid && last_beat;
    assign axi.axi_bready     = (state_q == S_RESP);
    assign writedone          = (state_q == S_DONE);
    assign busy               = busy_q;

endmodule

// File: tb/tb_send_matrix_c.sv
// Scoreboard bench for send_matrix_c: an AXI slave model checks every AW/W handshake against
// expectations queued when each run is started.
module tb_send_matrix_c;
    import matrix_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DONE_CYCLE = 321;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        writestart;
    logic [1:0]  mtype;
    logic [31:0] mat [0:3][0:7][0:7];
    logic        busy, writedone, write_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_aw_q[$];
    beat_t       exp_w_q[$];
    logic [31:0] aw_log [0:63];
    int          aw_seen, w_seen, b_seen;
    int          aw_delay   = 0;
    int          wready_pct = 100;
    int          err_burst  = -1;
    int          aw_wait;
    logic        b_pending, aw_hold, w_hold;
    logic [31:0] aw_hold_addr;
    beat_t       w_hold_beat;

    always #5 clk = ~clk;

    send_matrix_c_if #(.ADDR_W(ADDR_W)) axi ();

    send_matrix_c #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .writestart  (writestart),
        .Matrix_type (mtype),
        .Matrix_C_out(mat),
        .busy        (busy),
        .writedone   (writedone),
        .write_err   (write_err),
        .axi         (axi)
    );

    // Slave model: readies are chosen on the falling edge, and the handshakes they produce
    // at the next rising edge are scored right away.
    initial begin : slave
        axi.axi_awready = 1'b0;
        axi.axi_wready  = 1'b0;
        axi.axi_bvalid  = 1'b0;
        axi.axi_bresp   = 2'b00;
        b_pending = 1'b0; aw_hold = 1'b0; w_hold = 1'b0; aw_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.axi_awready = 1'b0;
                axi.axi_wready  = 1'b0;
                axi.axi_bvalid  = 1'b0;
                axi.axi_bresp   = 2'b00;
                b_pending = 1'b0; aw_hold = 1'b0; w_hold = 1'b0; aw_wait = 0;
            end else begin
                if (aw_hold) begin
                    n_checks++;
                    if (axi.axi_awvalid !== 1'b1 || axi.axi_awaddr !== aw_hold_addr)
                        $display("FAIL aw_stall_stable: awvalid=%b awaddr=%h, required awvalid=1 awaddr=%h",
                                 axi.axi_awvalid, axi.axi_awaddr, aw_hold_addr);
                    else n_pass++;
                end
                if (w_hold) begin
                    n_checks++;
                    if (axi.axi_wvalid !== 1'b1 || axi.axi_wdata !== w_hold_beat.data ||
                        axi.axi_wlast !== w_hold_beat.last)
                        $display("FAIL w_stall_stable: wvalid=%b wdata=%h wlast=%b, required 1/%h/%b",
                                 axi.axi_wvalid, axi.axi_wdata, axi.axi_wlast,
                                 w_hold_beat.data, w_hold_beat.last);
                    else n_pass++;
                end

                axi.axi_awready = axi.axi_awvalid && (aw_wait >= aw_delay);
                if (axi.axi_awvalid && !axi.axi_awready) aw_wait++;
                axi.axi_wready  = ($urandom_range(99) < wready_pct);
                axi.axi_bvalid  = b_pending;
                axi.axi_bresp   = (b_pending && b_seen == err_burst) ? 2'b10 : 2'b00;

                aw_hold = axi.axi_awvalid && !axi.axi_awready;
                if (aw_hold) aw_hold_addr = axi.axi_awaddr;
                if (axi.axi_awvalid && axi.axi_awready) begin
                    logic [31:0] exp_a;
                    aw_wait = 0;
                    if (aw_seen < 64) aw_log[aw_seen] = axi.axi_awaddr;
                    aw_seen++;
                    n_checks++;
                    if (exp_aw_q.size() == 0) begin
                        $display("FAIL aw_unexpected: awaddr=%h, required no AW", axi.axi_awaddr);
                    end else begin
                        exp_a = exp_aw_q.pop_front();
                        if (axi.axi_awaddr !== exp_a)
                            $display("FAIL awaddr: got %h, required %h", axi.axi_awaddr, exp_a);
                        else n_pass++;
                    end
                    n_checks++;
                    if ({axi.axi_awlen, axi.axi_awsize, axi.axi_awburst} !== {8'd7, 3'b010, 2'b01})
                        $display("FAIL aw_attr: len=%0d size=%b burst=%b, required 7/010/01",
                                 axi.axi_awlen, axi.axi_awsize, axi.axi_awburst);
                    else n_pass++;
                end

                if (axi.axi_bvalid && axi.axi_bready) begin
                    b_pending = 1'b0;
                    b_seen++;
                end

                w_hold = axi.axi_wvalid && !axi.axi_wready;
                if (w_hold) w_hold_beat = '{data: axi.axi_wdata, last: axi.axi_wlast};
                if (axi.axi_wvalid && axi.axi_wready) begin
                    beat_t exp_b;
                    n_checks++;
                    if (w_seen >= aw_seen * 8)
                        $display("FAIL w_order: beat %0d before its AW, AWs accepted=%0d", w_seen, aw_seen);
                    else n_pass++;
                    n_checks++;
                    if (exp_w_q.size() == 0) begin
                        $display("FAIL w_unexpected: wdata=%h, required no beat", axi.axi_wdata);
                    end else begin
                        exp_b = exp_w_q.pop_front();
                        if (axi.axi_wdata !== exp_b.data || axi.axi_wlast !== exp_b.last)
                            $display("FAIL wbeat %0d: got %h last=%b, required %h last=%b", w_seen,
                                     axi.axi_wdata, axi.axi_wlast, exp_b.data, exp_b.last);
                        else n_pass++;
                    end
                    n_checks++;
                    if (axi.axi_wstrb !== 4'hF)
                        $display("FAIL wstrb: got %h, required f", axi.axi_wstrb);
                    else n_pass++;
                    w_seen++;
                    if (axi.axi_wlast) b_pending = 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] addr_model(int ty, int t, int r);
        int mc, n;
        case (ty)
            1:       begin mc = 2; n = 16; end
            2:       begin mc = 1; n = 8;  end
            default: begin mc = 4; n = 32; end
        endcase
        return 32'((((t / mc) * 8 + r) * n + (t % mc) * 8) * 4);
    endfunction

    task automatic fill_pattern();
        for (int t = 0; t < 4; t++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mat[t][r][c] = {8'h00, 8'(t), 8'(r), 8'(c)};
    endtask

    task automatic fill_random();
        for (int t = 0; t < 4; t++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mat[t][r][c] = $urandom();
    endtask

    task automatic clear_sb();
        exp_aw_q.delete();
        exp_w_q.delete();
        aw_seen = 0; w_seen = 0; b_seen = 0;
        for (int i = 0; i < 64; i++) aw_log[i] = 32'hDEAD_BEEF;
    endtask

    task automatic push_expect(int ty);
        for (int t = 0; t < 4; t++)
            for (int r = 0; r < 8; r++) begin
                exp_aw_q.push_back(addr_model(ty, t, r));
                for (int b = 0; b < 8; b++)
                    exp_w_q.push_back('{data: mat[t][r][b], last: (b == 7)});
            end
    endtask

    // Called between a falling edge and the next rising edge; returns just after the accepting edge.
    task automatic pulse_start(int ty);
        mtype      = 2'(ty);
        writestart = 1'b1;
        @(posedge clk);
        #1;
        writestart = 1'b0;
        mtype      = 2'($urandom_range(3));
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit seen,
                             output logic busy1, output logic busy_at_done);
        cyc = 0; seen = 1'b0; busy1 = 1'bx; busy_at_done = 1'bx;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == 1) busy1 = busy;
            if (writedone) begin
                seen = 1'b1;
                busy_at_done = busy;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; writestart = 1'b0; mtype = 2'd0;
        fill_pattern();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, writedone, write_err, axi.axi_bready} !== 4'b0)
            $display("FAIL reset_ctrl: busy/done/err/bready=%b, required 0000",
                     {busy, writedone, write_err, axi.axi_bready});
        else n_pass++;
        n_checks++;
        if ({axi.axi_awvalid, axi.axi_awaddr, axi.axi_awlen, axi.axi_awsize, axi.axi_awburst} !== '0)
            $display("FAIL reset_aw: awvalid=%b awaddr=%h, required all 0", axi.axi_awvalid, axi.axi_awaddr);
        else n_pass++;
        n_checks++;
        if ({axi.axi_wvalid, axi.axi_wdata, axi.axi_wstrb, axi.axi_wlast} !== '0)
            $display("FAIL reset_w: wvalid=%b wdata=%h, required all 0", axi.axi_wvalid, axi.axi_wdata);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_type(int ty, int fill_pat);
        int cyc; bit seen; logic b1, bd, bad;
        int          idx [4];
        logic [31:0] ref_a [4];
        case (ty)
            0:       begin idx = '{0, 1, 8, 31};  ref_a = '{32'h000, 32'h080, 32'h020, 32'h3E0}; end
            1:       begin idx = '{16, 31, 8, 0}; ref_a = '{32'h200, 32'h3E0, 32'h020, 32'h000}; end
            default: begin idx = '{8, 31, 1, 0};  ref_a = '{32'h100, 32'h3E0, 32'h020, 32'h000}; end
        endcase
        clear_sb();
        if (fill_pat != 0) fill_pattern(); else fill_random();
        push_expect(ty);
        pulse_start(ty);
        wait_done(2000, cyc, seen, b1, bd);
        n_checks++;
        if (!seen || cyc != DONE_CYCLE)
            $display("FAIL type%0d_latency: writedone seen=%0b at cycle %0d, required cycle %0d",
                     ty, seen, cyc, DONE_CYCLE);
        else n_pass++;
        n_checks++;
        if (b1 !== 1'b1 || bd !== 1'b0)
            $display("FAIL type%0d_busy: busy after start=%b at done=%b, required 1/0", ty, b1, bd);
        else n_pass++;
        n_checks++;
        if (aw_seen != 32 || w_seen != 256 || exp_aw_q.size() != 0 || exp_w_q.size() != 0 || write_err !== 1'b0)
            $display("FAIL type%0d_totals: AW=%0d W=%0d left=%0d/%0d err=%b, required 32/256/0/0/0",
                     ty, aw_seen, w_seen, exp_aw_q.size(), exp_w_q.size(), write_err);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (aw_log[idx[i]] !== ref_a[i])
                $display("FAIL type%0d_addr burst %0d: got %h, required %h", ty, idx[i], aw_log[idx[i]], ref_a[i]);
            else n_pass++;
        end
        bad = 1'b0;
        for (int i = 0; i < 32; i++) if (aw_log[i][4:0] != 5'd0) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL type%0d_align: some awaddr not multiple of 0x20, required all aligned", ty);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (writedone !== 1'b0 || busy !== 1'b0)
            $display("FAIL type%0d_pulse: writedone=%b busy=%b one cycle later, required 0/0", ty, writedone, busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        int cyc; bit seen; logic b1, bd;
        aw_delay = 3; wready_pct = 50;
        clear_sb();
        fill_random();
        push_expect(0);
        pulse_start(0);
        repeat (40) @(negedge clk);
        mtype = 2'd2; writestart = 1'b1;
        @(posedge clk);
        #1;
        writestart = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL stall_busy: busy=%b after mid-run start, required 1", busy);
        else n_pass++;
        wait_done(5000, cyc, seen, b1, bd);
        n_checks++;
        if (!seen) $display("FAIL stall_done: no writedone within 5000 cycles, required one");
        else n_pass++;
        n_checks++;
        if (aw_seen != 32 || w_seen != 256 || exp_aw_q.size() != 0 || exp_w_q.size() != 0)
            $display("FAIL stall_totals: AW=%0d W=%0d left=%0d/%0d, required 32/256/0/0",
                     aw_seen, w_seen, exp_aw_q.size(), exp_w_q.size());
        else n_pass++;
        aw_delay = 0; wready_pct = 100;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen, found, saw_done; logic b1, bd;
        clear_sb();
        fill_pattern();
        push_expect(0);
        pulse_start(0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1;
            if (axi.axi_wvalid && axi.axi_wdata == 32'h0000_0004) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL rstmid_reach: beat 4 never presented within 50 cycles, required it");
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, writedone, axi.axi_awvalid, axi.axi_wvalid, axi.axi_bready, axi.axi_wlast} !== '0 ||
            axi.axi_wdata !== '0 || axi.axi_awaddr !== '0)
            $display("FAIL rstmid_outputs: busy=%b wvalid=%b wdata=%h, required all 0",
                     busy, axi.axi_wvalid, axi.axi_wdata);
        else n_pass++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (writedone) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (writedone) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) $display("FAIL rstmid_nodone: writedone seen after abort, required none");
        else n_pass++;
        clear_sb();
        push_expect(0);
        pulse_start(0);
        wait_done(2000, cyc, seen, b1, bd);
        n_checks++;
        if (!seen || cyc != DONE_CYCLE || aw_log[0] !== 32'h0 || exp_w_q.size() != 0)
            $display("FAIL rstmid_restart: done=%0b cyc=%0d first awaddr=%h left=%0d, required 1/%0d/0/0",
                     seen, cyc, aw_log[0], exp_w_q.size(), DONE_CYCLE);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_resp_err();
        int cyc; bit seen; logic b1, bd;
        clear_sb();
        fill_random();
        err_burst = 4;
        push_expect(0);
        pulse_start(0);
        wait_done(2000, cyc, seen, b1, bd);
        err_burst = -1;
`ifdef SEND_C_RESP_CHECK_EN
        n_checks++;
        if (!seen || aw_seen != 5 || write_err !== 1'b1)
            $display("FAIL resp_abort: done=%0b AWs=%0d err=%b, required 1/5/1", seen, aw_seen, write_err);
        else n_pass++;
        @(negedge clk);
        clear_sb();
        push_expect(0);
        pulse_start(0);
        @(negedge clk);
        #1;
        n_checks++;
        if (write_err !== 1'b0) $display("FAIL resp_clear: write_err=%b after new start, required 0", write_err);
        else n_pass++;
        wait_done(2000, cyc, seen, b1, bd);
        n_checks++;
        if (!seen || aw_seen != 32) $display("FAIL resp_rerun: done=%0b AWs=%0d, required 1/32", seen, aw_seen);
        else n_pass++;
`else
        n_checks++;
        if (!seen || cyc != DONE_CYCLE || aw_seen != 32 || w_seen != 256 || write_err !== 1'b0)
            $display("FAIL resp_ignored: done=%0b cyc=%0d AWs=%0d W=%0d err=%b, required 1/%0d/32/256/0",
                     seen, cyc, aw_seen, w_seen, write_err, DONE_CYCLE);
        else n_pass++;
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; logic b1, bd;
        clear_sb();
        fill_random();
        push_expect(1);
        pulse_start(1);
        wait_done(2000, cyc, seen, b1, bd);
        @(negedge clk);
        clear_sb();
        fill_random();
        push_expect(2);
        pulse_start(2);
        wait_done(2000, cyc, seen, b1, bd);
        n_checks++;
        if (!seen || cyc != DONE_CYCLE || b1 !== 1'b1 || exp_aw_q.size() != 0 || exp_w_q.size() != 0)
            $display("FAIL b2b: done=%0b cyc=%0d busy=%b left=%0d/%0d, required 1/%0d/1/0/0",
                     seen, cyc, b1, exp_aw_q.size(), exp_w_q.size(), DONE_CYCLE);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        writestart = 1'b0;
        mtype = 2'd0;
        test_reset();
        test_type(0, 1);
        test_type(1, 0);
        test_type(2, 0);
        test_stall();
        test_reset_mid();
        test_resp_err();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
